// File: rtl/alu_status_reg_pkg.sv
// alu_status_reg_pkg
//   Shared definitions for the ALU status register slice.
//   - `STATUS_*_BIT : flag bit positions inside the status word (V N Z C).
//     They are normally provided by the components include file.
//     The guards below reuse those values when already defined.
//   - `COND_*       : condition-code encodings 0..15 for cond evaluation.
//   - status_src_e  : selects which source loads the status register.
//   - Default widths/depths for the top-level parameters.

`ifndef STATUS_V_BIT
`define STATUS_V_BIT 3
`endif
`ifndef STATUS_N_BIT
`define STATUS_N_BIT 2
`endif
`ifndef STATUS_Z_BIT
`define STATUS_Z_BIT 1
`endif
`ifndef STATUS_C_BIT
`define STATUS_C_BIT 0
`endif

`ifndef COND_CODES_DEFINED
`define COND_CODES_DEFINED
`define COND_EQ 4'd0
`define COND_NE 4'd1
`define COND_CS 4'd2
`define COND_CC 4'd3
`define COND_MI 4'd4
`define COND_PL 4'd5
`define COND_VS 4'd6
`define COND_VC 4'd7
`define COND_HI 4'd8
`define COND_LS 4'd9
`define COND_GE 4'd10
`define COND_LT 4'd11
`define COND_GT 4'd12
`define COND_LE 4'd13
`define COND_AL 4'd14
`define COND_NV 4'd15
`endif

package alu_status_reg_pkg;

    localparam int STATUS_WIDTH_DEF = 4;
    localparam int STACK_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        SRC_HOLD    = 2'd0,
        SRC_RESTORE = 2'd1,
        SRC_SW      = 2'd2,
        SRC_CAPTURE = 2'd3
    } status_src_e;

endpackage

// File: rtl/alu_status_reg_if.sv
// alu_status_if
//   Groups the status-register bus between the ALU/control side (master)
//   and the status register (slave).
//   master drives: alu_so, flags_we, flags_mask, sw_we, sw_data, cond,
//                  save, restore
//   slave drives : status, cond_true, stack_full, stack_empty, stack_err,
//                  sticky_v

interface alu_status_if #(
    parameter int STATUS_WIDTH = 4
);
    logic [STATUS_WIDTH-1:0] alu_so;
    logic                    flags_we;
    logic [STATUS_WIDTH-1:0] flags_mask;
    logic                    sw_we;
    logic [STATUS_WIDTH-1:0] sw_data;
    logic [STATUS_WIDTH-1:0] status;
    logic [3:0]              cond;
    logic                    cond_true;
    logic                    save;
    logic                    restore;
    logic                    stack_full;
    logic                    stack_empty;
    logic                    stack_err;
    logic                    sticky_v;

    modport master (
        output alu_so, flags_we, flags_mask, sw_we, sw_data, cond, save, restore,
        input  status, cond_true, stack_full, stack_empty, stack_err, sticky_v
    );

    modport slave (
        input  alu_so, flags_we, flags_mask, sw_we, sw_data, cond, save, restore,
        output status, cond_true, stack_full, stack_empty, stack_err, sticky_v
    );
endinterface

// File: rtl/alu_status_stack.sv
// alu_status_stack
//   Small LIFO used as the flag shadow stack.
//   Ports:
//     clk, rst_n    : clock, async active-low reset
//     push_i/pop_i  : push data_i / pop the top entry
//     data_i        : value to push
//     top_o         : current top entry (valid when !empty_o)
//     full_o/empty_o: occupancy flags
//     err_o         : sticky error (overflow, underflow, push+pop conflict)
//     push_ok_o     : push is performed this cycle
//     pop_ok_o      : pop is performed this cycle
//     err_evt_o     : this cycle's request is an error and is dropped
//   Entry contents are not reset; only the pointer is.

module alu_status_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o,
    output logic             push_ok_o,
    output logic             pop_ok_o,
    output logic             err_evt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    top_idx;

    assign full_o  = (sp_q == PW'(DEPTH));
    assign empty_o = (sp_q == '0);

    // Conflicting push+pop is rejected outright, like overflow/underflow.
    assign err_evt_o = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);
    assign push_ok_o = push_i & ~pop_i & ~full_o;
    assign pop_ok_o  = pop_i & ~push_i & ~empty_o;

    // When sp == DEPTH the low bits are 0, so subtracting 1 still lands on DEPTH-1.
    assign top_idx = sp_q[AW-1:0] - AW'(1);
    assign top_o   = mem_q[top_idx];
    assign err_o   = err_q;

    always_comb begin
        sp_d  = sp_q;
        err_d = err_q | err_evt_o;
        if (push_ok_o) begin
            sp_d = sp_q + PW'(1);
        end else if (pop_ok_o) begin
            sp_d = sp_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o) begin
            mem_q[sp_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/alu_status_reg.sv
// alu_status_reg
//   Holds the ALU status word (V N Z C), feeds it back to the ALU, evaluates
//   a 4-bit condition code against it, and saves/restores it through a
//   shadow stack across exception entry/return.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : async active-low reset
//     bus   : alu_status_if.slave (capture, software write, cond select,
//             save/restore in; status, cond_true, stack flags, sticky_v out)
//   Load priority: valid restore > software write > masked capture.
//   A rejected stack request (overflow, underflow, save+restore) leaves
//   the status untouched for that cycle.
//   Optional: STATUS_STICKY_OV_EN adds a sticky overflow flag; without it
//   sticky_v is tied low.

module alu_status_reg
    import alu_status_reg_pkg::*;
#(
    parameter int STATUS_WIDTH = STATUS_WIDTH_DEF,
    parameter int STACK_DEPTH  = STACK_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_status_if.slave  bus
);
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic [STATUS_WIDTH-1:0] stack_top;
    status_src_e             src;
    logic                    push_ok, pop_ok, err_evt;
    logic                    v, n, z, c;

    alu_status_stack #(
        .WIDTH (STATUS_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (bus.save),
        .pop_i     (bus.restore),
        .data_i    (status_q),
        .top_o     (stack_top),
        .full_o    (bus.stack_full),
        .empty_o   (bus.stack_empty),
        .err_o     (bus.stack_err),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok),
        .err_evt_o (err_evt)
    );

    always_comb begin
        src = SRC_HOLD;
        if (pop_ok) begin
            src = SRC_RESTORE;
        end else if (!err_evt && bus.sw_we) begin
            src = SRC_SW;
        end else if (!err_evt && bus.flags_we) begin
            src = SRC_CAPTURE;
        end
    end

    always_comb begin
        status_d = status_q;
        case (src)
            SRC_RESTORE: status_d = stack_top;
            SRC_SW:      status_d = bus.sw_data;
            SRC_CAPTURE: status_d = (status_q & ~bus.flags_mask) | (bus.alu_so & bus.flags_mask);
            default:     status_d = status_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status = status_q;

    assign v = status_q[`STATUS_V_BIT];
    assign n = status_q[`STATUS_N_BIT];
    assign z = status_q[`STATUS_Z_BIT];
    assign c = status_q[`STATUS_C_BIT];

    always_comb begin
        bus.cond_true = 1'b0;
        case (bus.cond)
            `COND_EQ: bus.cond_true = z;
            `COND_NE: bus.cond_true = ~z;
            `COND_CS: bus.cond_true = c;
            `COND_CC: bus.cond_true = ~c;
            `COND_MI: bus.cond_true = n;
            `COND_PL: bus.cond_true = ~n;
            `COND_VS: bus.cond_true = v;
            `COND_VC: bus.cond_true = ~v;
            `COND_HI: bus.cond_true = c & ~z;
            `COND_LS: bus.cond_true = ~c | z;
            `COND_GE: bus.cond_true = (n == v);
            `COND_LT: bus.cond_true = (n != v);
            `COND_GT: bus.cond_true = ~z & (n == v);
            `COND_LE: bus.cond_true = z | (n != v);
            `COND_AL: bus.cond_true = 1'b1;
            `COND_NV: bus.cond_true = 1'b0;
            default:  bus.cond_true = 1'b0;
        endcase
    end

`ifdef STATUS_STICKY_OV_EN
    logic sticky_q, sticky_d;

    // A software write with V=0 wins over any same-cycle set.
    always_comb begin
        sticky_d = sticky_q;
        if (src == SRC_SW && !bus.sw_data[`STATUS_V_BIT]) begin
            sticky_d = 1'b0;
        end else if (status_d[`STATUS_V_BIT]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky_v = sticky_q;
`else
    assign bus.sticky_v = 1'b0;
`endif
endmodule

// File: tb/tb_alu_status_reg.sv
module tb_alu_status_reg;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        logic [3:0] status;
        logic       full;
        logic       empty;
        logic       err;
        logic       sticky;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    exp_t       sb_q[$];
    logic [3:0] m_stack[$];
    logic [3:0] m_status;
    logic       m_err;
    logic       m_sticky;

    alu_status_if #(.STATUS_WIDTH(W)) bus ();

    alu_status_reg #(
        .STATUS_WIDTH (W),
        .STACK_DEPTH  (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout actual=running required=finished");
        $fatal(1);
    end

    // Bench model of the condition table, written from the V N Z C definitions.
    function automatic logic cond_model(input logic [3:0] s, input logic [3:0] cc);
        logic v, n, z, c;
        v = s[3]; n = s[2]; z = s[1]; c = s[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.status = m_status;
        e.full   = (m_stack.size() == D);
        e.empty  = (m_stack.size() == 0);
        e.err    = m_err;
`ifdef STATUS_STICKY_OV_EN
        e.sticky = m_sticky;
`else
        e.sticky = 1'b0;
`endif
        return e;
    endfunction

    task automatic idle();
        bus.alu_so = '0; bus.flags_we = 1'b0; bus.flags_mask = '0;
        bus.sw_we = 1'b0; bus.sw_data = '0; bus.save = 1'b0; bus.restore = 1'b0;
    endtask

    // Drives one cycle of stimulus, advances the model and queues the expectation.
    task automatic step(input logic fw, input logic [3:0] mask, input logic [3:0] so,
                        input logic sww, input logic [3:0] swd,
                        input logic sv, input logic rs);
        logic err_ev;
        logic sw_applied;
        err_ev = (sv && rs) || (sv && m_stack.size() == D) || (rs && m_stack.size() == 0);
        sw_applied = 1'b0;
        if (err_ev) begin
            m_err = 1'b1;
        end else if (rs) begin
            m_status = m_stack.pop_back();
        end else begin
            if (sv) m_stack.push_back(m_status);
            if (sww) begin
                m_status = swd;
                sw_applied = 1'b1;
            end else if (fw) begin
                m_status = (m_status & ~mask) | (so & mask);
            end
        end
        if (sw_applied && !swd[3]) m_sticky = 1'b0;
        else if (m_status[3]) m_sticky = 1'b1;
        sb_q.push_back(snap());

        bus.flags_we = fw; bus.flags_mask = mask; bus.alu_so = so;
        bus.sw_we = sww; bus.sw_data = swd; bus.save = sv; bus.restore = rs;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        m_status = '0; m_err = 1'b0; m_sticky = 1'b0;
        m_stack.delete();
        sb_q.push_back(snap());
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status) begin n_fail++; $display("FAIL reset_status: actual=%h required=%h", bus.status, e.status); end
        n_cmp++;
        if (bus.stack_empty !== e.empty || bus.stack_full !== e.full) begin
            n_fail++; $display("FAIL reset_stack: empty=%b full=%b required empty=%b full=%b", bus.stack_empty, bus.stack_full, e.empty, e.full);
        end
        n_cmp++;
        if (bus.stack_err !== e.err || bus.sticky_v !== e.sticky) begin
            n_fail++; $display("FAIL reset_err_sticky: err=%b sticky=%b required err=%b sticky=%b", bus.stack_err, bus.sticky_v, e.err, e.sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_capture();
        exp_t e;
        step(1'b1, 4'hF, 4'b1001, 1'b0, 4'h0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status) begin n_fail++; $display("FAIL capture_status: actual=%h required=%h", bus.status, e.status); end
        bus.cond = 4'd8; #1;
        n_cmp++;
        if (bus.cond_true !== 1'b1) begin n_fail++; $display("FAIL cond_hi: actual=%b required=1", bus.cond_true); end
        bus.cond = 4'd10; #1;
        n_cmp++;
        if (bus.cond_true !== 1'b0) begin n_fail++; $display("FAIL cond_ge: actual=%b required=0", bus.cond_true); end
        for (int cc = 0; cc < 16; cc++) begin
            bus.cond = 4'(cc); #1;
            n_cmp++;
            if (bus.cond_true !== cond_model(e.status, 4'(cc))) begin
                n_fail++; $display("FAIL cond_table[%0d]: actual=%b required=%b", cc, bus.cond_true, cond_model(e.status, 4'(cc)));
            end
        end
    endtask

    task automatic test_mask();
        exp_t e;
        logic [11:0] sum;
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status) begin n_fail++; $display("FAIL mask_setup: actual=%h required=%h", bus.status, e.status); end
        step(1'b1, 4'b0001, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status) begin n_fail++; $display("FAIL mask_capture: actual=%h required=%h", bus.status, e.status); end
        sum = 12'habc + 12'h123 + {11'b0, bus.status[0]};
        n_cmp++;
        if (sum !== 12'hbdf) begin n_fail++; $display("FAIL alu_add_carry_in: actual=%h required=bdf", sum); end
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0] rc;
        for (int i = 0; i < 24; i++) begin
            step($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 3) == 0, 4'($urandom), 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.status !== e.status) begin n_fail++; $display("FAIL random_status[%0d]: actual=%h required=%h", i, bus.status, e.status); end
            rc = 4'($urandom);
            bus.cond = rc; #1;
            n_cmp++;
            if (bus.cond_true !== cond_model(e.status, rc)) begin
                n_fail++; $display("FAIL random_cond[%0d]: cond=%0d actual=%b required=%b", i, rc, bus.cond_true, cond_model(e.status, rc));
            end
            n_cmp++;
            if (bus.sticky_v !== e.sticky) begin n_fail++; $display("FAIL random_sticky[%0d]: actual=%b required=%b", i, bus.sticky_v, e.sticky); end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0100, 1'b0, 1'b0);
        e = sb_q.pop_front();
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        e = sb_q.pop_front();
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.stack_empty !== e.empty) begin n_fail++; $display("FAIL prio_setup_empty: actual=%b required=%b", bus.stack_empty, e.empty); end
        step(1'b1, 4'hF, 4'b1010, 1'b1, 4'b1111, 1'b0, 1'b1);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status) begin n_fail++; $display("FAIL prio_restore_wins: actual=%h required=%h", bus.status, e.status); end
        n_cmp++;
        if (bus.stack_empty !== e.empty || bus.stack_err !== e.err) begin
            n_fail++; $display("FAIL prio_stack: empty=%b err=%b required empty=%b err=%b", bus.stack_empty, bus.stack_err, e.empty, e.err);
        end
    endtask

    task automatic test_stack();
        exp_t e;
        logic [3:0] vals [5];
        vals[0] = 4'h5; vals[1] = 4'h9; vals[2] = 4'hE; vals[3] = 4'h6; vals[4] = 4'hA;
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0);
        e = sb_q.pop_front();
        // Each save pushes the pre-update status while the same-cycle write lands.
        for (int i = 0; i < D; i++) begin
            step(1'b0, 4'h0, 4'h0, 1'b1, vals[i], 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.status !== e.status || bus.stack_full !== e.full || bus.stack_empty !== e.empty || bus.stack_err !== e.err) begin
                n_fail++; $display("FAIL push[%0d]: status=%h full=%b empty=%b err=%b required %h %b %b %b",
                                   i, bus.status, bus.stack_full, bus.stack_empty, bus.stack_err, e.status, e.full, e.empty, e.err);
            end
        end
        step(1'b0, 4'h0, 4'h0, 1'b1, vals[4], 1'b1, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.stack_err !== e.err || bus.stack_full !== e.full || bus.status !== e.status) begin
            n_fail++; $display("FAIL overflow: err=%b full=%b status=%h required err=%b full=%b status=%h",
                               bus.stack_err, bus.stack_full, bus.status, e.err, e.full, e.status);
        end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.status !== e.status || bus.stack_full !== e.full || bus.stack_empty !== e.empty) begin
                n_fail++; $display("FAIL pop[%0d]: status=%h full=%b empty=%b required %h %b %b",
                                   i, bus.status, bus.stack_full, bus.stack_empty, e.status, e.full, e.empty);
            end
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0);
        e = sb_q.pop_front();
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        e = sb_q.pop_front();
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.stack_err !== e.err) begin n_fail++; $display("FAIL conflict_pre_err: actual=%b required=%b", bus.stack_err, e.err); end
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.stack_err !== e.err || bus.status !== e.status || bus.stack_empty !== e.empty) begin
            n_fail++; $display("FAIL conflict: err=%b status=%h empty=%b required err=%b status=%h empty=%b",
                               bus.stack_err, bus.status, bus.stack_empty, e.err, e.status, e.empty);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.status !== e.status || bus.stack_empty !== e.empty) begin
            n_fail++; $display("FAIL conflict_then_pop: status=%h empty=%b required status=%h empty=%b", bus.status, bus.stack_empty, e.status, e.empty);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.stack_err !== e.err || bus.status !== e.status || bus.stack_empty !== e.empty) begin
            n_fail++; $display("FAIL underflow: err=%b status=%h empty=%b required err=%b status=%h empty=%b",
                               bus.stack_err, bus.status, bus.stack_empty, e.err, e.status, e.empty);
        end
    endtask

    task automatic test_sticky();
        exp_t e;
        step(1'b1, 4'hF, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.sticky_v !== e.sticky) begin n_fail++; $display("FAIL sticky_set: actual=%b required=%b", bus.sticky_v, e.sticky); end
        step(1'b1, 4'hF, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.sticky_v !== e.sticky || bus.status !== e.status) begin
            n_fail++; $display("FAIL sticky_hold: sticky=%b status=%h required sticky=%b status=%h", bus.sticky_v, bus.status, e.sticky, e.status);
        end
        step(1'b1, 4'hF, 4'b1000, 1'b1, 4'b0001, 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.sticky_v !== e.sticky || bus.status !== e.status) begin
            n_fail++; $display("FAIL sticky_sw_clear: sticky=%b status=%h required sticky=%b status=%h", bus.sticky_v, bus.status, e.sticky, e.status);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b1;
        bus.cond = 4'd0;
        idle();
        m_status = '0; m_err = 1'b0; m_sticky = 1'b0;

        test_reset();
        test_capture();
        test_mask();
        test_random();
        test_priority();
        test_stack();
        test_reset();
        test_conflict();
        test_reset();
        test_sticky();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_status_reg.md
Name: alu_status_reg

Overview:
Holds the 4-bit ALU status word (V, N, Z, C). It captures the ALU's status output and returns the held value to the ALU's status input (carry-in for ADD), closing the status loop.
It also evaluates a 4-bit branch/condition code against the held flags for the control path.
A small LIFO shadow stack saves and restores the flags across exception entry and return.

Parameters:
STATUS_WIDTH, 4, status word width; bit positions come from `STATUS_V_BIT / `STATUS_N_BIT / `STATUS_Z_BIT / `STATUS_C_BIT.
STACK_DEPTH, 4, number of shadow-stack entries (power of two, at least 2).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
alu_so  input  STATUS_WIDTH  status out from the ALU
flags_we  input  1  capture alu_so into the status register
flags_mask  input  STATUS_WIDTH  per-bit enable for the flags_we capture
sw_we  input  1  software write of the status register
sw_data  input  STATUS_WIDTH  software write data
status  output  STATUS_WIDTH  registered flags; drives the ALU status in
cond  input  4  condition code select
cond_true  output  1  result of the condition evaluation
save  input  1  push status onto the shadow stack
restore  input  1  pop the stack top into status
stack_full  output  1  stack holds STACK_DEPTH entries
stack_empty  output  1  stack holds no entries
stack_err  output  1  sticky overflow/underflow/conflict flag
sticky_v  output  1  sticky overflow; see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous):
  - status = 0, stack pointer = 0, stack_empty = 1, stack_full = 0, stack_err = 0, sticky_v = 0.
  - Stack entry contents are don't-care.
- Status register update, one-cycle latency. The value written at edge n is visible on status after edge n.
- Write-source priority per cycle:
  1. Valid restore: status <= top entry.
  2. Otherwise sw_we: status <= sw_data.
  3. Otherwise flags_we: status[i] <= flags_mask[i] ? alu_so[i] : status[i].
- cond_true is combinational from the registered status and cond:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C & !Z. 9 LS: !C | Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z & (N==V). 13 LE: Z | (N!=V).
  - 14 AL: 1. 15 NV: 0.
- Shadow stack:
  - Pointer sp counts 0..STACK_DEPTH.
  - stack_full = (sp == STACK_DEPTH); stack_empty = (sp == 0).
- save with !full:
  - Stores the current registered status (the pre-update value) at entry sp, then sp++.
  - A same-cycle flags_we or sw_we still applies to status.
- restore with !empty: sp--; status <= entry[sp-1]. Same-cycle flags_we and sw_we are ignored.
- Error cases: stack_err is set, nothing changes, and sp does not wrap.
  - save while full.
  - restore while empty.
  - save and restore asserted in the same cycle (neither the push nor the pop is performed).
- stack_err is cleared only by reset.
- A reset asserted mid-operation discards all stack contents immediately.

Optional Feature:
Macro STATUS_STICKY_OV_EN.
- Defined:
  - sticky_v sets on any cycle where the new status V bit is 1, whether from capture, software write or restore.
  - sticky_v clears only on sw_we with sw_data V bit = 0, or on reset.
  - A software write with V = 0 clears sticky_v even when a same-cycle capture would set it.
- Not defined: sticky_v is tied to 0 and no extra flops exist.

Decomposition:
- Shared header (the existing components include file):
  - The `STATUS_*_BIT positions, already defined there and reused.
  - New `COND_EQ..`COND_NV condition-code constants 0..15.
- One natural sub-module: alu_status_stack. It is a parameterised LIFO with push, pop, full, empty and err, instantiated once.
- The condition evaluator stays inline as a combinational case.

Test Plan:
1. Reset, then flags_we=1, mask=F, alu_so=V1 N0 Z0 C1 -> next cycle status=V1 N0 Z0 C1. cond=HI -> cond_true=1; cond=GE -> 0.
2. status=C1, then flags_we with mask=0001 and alu_so=1110 -> status C=0, V/N/Z unchanged at 0. Feed status to the ALU, ADD 0xabc+0x123 -> 0xbdf (no carry-in).
3. Push STACK_DEPTH distinct values -> stack_full=1. One more save -> stack_err=1, sp unchanged. Pop all -> values return in reverse order and stack_empty=1.
4. Same cycle: restore (top=0100) + sw_we=1111 + flags_we -> status=0100.
5. Same cycle: save + restore -> stack_err=1, sp and status unchanged. Then restore when empty -> still stack_err=1, status unchanged.
6. With STATUS_STICKY_OV_EN: capture V=1 then V=0 -> sticky_v stays 1. sw_we with V=0 -> sticky_v=0. Without the macro -> sticky_v=0 throughout.
